// File: rtl/letc_core_stage_ctrl.sv
// Per-stage output register plus a one-outstanding request/response sequencer for a
// multicycle side unit; produces the stage ready bit consumed by the hazard unit.
module letc_core_stage_ctrl #(
    parameter int PAYLOAD_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_flush,
    output logic                 o_ready,
    input  logic                 i_valid,
    input  logic                 i_needs_req,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_req_valid,
    input  logic                 i_req_ready,
    input  logic                 i_rsp_valid,
    input  logic [31:0]          i_rsp_data,
    output logic                 o_valid,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic [31:0]          o_rsp_data
);

    // state | meaning
    // IDLE  | no side-unit transaction in progress
    // REQ   | request presented, waiting for accept
    // WAIT  | request accepted, waiting for response
    // DONE  | response held, waiting for the output load
    // DRAIN | response pending for a flushed instruction, will be dropped
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] rsp_held;

    // A no-request instruction queues behind DRAIN so responses stay in order.
    assign o_ready = ~i_valid
                   | (~i_needs_req & (state != S_DRAIN))
                   | (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_valid & i_needs_req & ~i_flush)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                if (i_flush)
                    state_nxt = i_req_ready ? S_DRAIN : S_IDLE;
                else if (i_req_ready)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_flush)
                    state_nxt = i_rsp_valid ? S_IDLE : S_DRAIN;
                else if (i_rsp_valid)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_flush | ~i_stall)
                    state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (i_rsp_valid)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            o_req_valid <= 1'b0;
            rsp_held    <= '0;
            o_valid     <= 1'b0;
            o_payload   <= '0;
            o_rsp_data  <= '0;
        end else begin
            state       <= state_nxt;
            o_req_valid <= (state_nxt == S_REQ);
            if ((state == S_WAIT) && i_rsp_valid && !i_flush)
                rsp_held <= i_rsp_data;
            // Flush bubbles the output; stall freezes every output flop.
            if (i_flush) begin
                o_valid <= 1'b0;
            end else if (!i_stall) begin
                o_valid   <= i_valid & o_ready;
                o_payload <= i_payload;
                if (state == S_DONE)
                    o_rsp_data <= rsp_held;
            end
        end
    end

endmodule

// File: tb/tb_letc_core_stage_ctrl.sv
// Random-stimulus bench for letc_core_stage_ctrl against a transaction-level model.
module tb_letc_core_stage_ctrl;

    localparam int PW = 64;
    localparam int N_CYC = 4000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, valid, needs_req, req_ready, rsp_valid;
    logic [PW-1:0] payload;
    logic [31:0]   rsp_data;
    logic          ready, req_valid, out_valid;
    logic [PW-1:0] out_payload;
    logic [31:0]   out_rsp;

    int n_chk = 0;
    int n_bad = 0;

    // Model: the outstanding transaction is tracked as flags, not as an FSM encoding.
    bit            m_reqp;   // request presented, not yet accepted
    bit            m_fly;    // accepted, response owed to a live instruction
    bit            m_doom;   // accepted, response owed to a flushed instruction
    bit            m_hit;    // response captured, waiting to move to the output
    logic [31:0]   m_held;
    bit            m_ov;
    logic [PW-1:0] m_op;
    logic [31:0]   m_ord;

    letc_core_stage_ctrl #(.PAYLOAD_W(PW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_stall     (stall),
        .i_flush     (flush),
        .o_ready     (ready),
        .i_valid     (valid),
        .i_needs_req (needs_req),
        .i_payload   (payload),
        .o_req_valid (req_valid),
        .i_req_ready (req_ready),
        .i_rsp_valid (rsp_valid),
        .i_rsp_data  (rsp_data),
        .o_valid     (out_valid),
        .o_payload   (out_payload),
        .o_rsp_data  (out_rsp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !valid || (!needs_req && !m_doom) || m_hit;
    endfunction

    task automatic model_step();
        bit rdy;
        rdy = model_ready();
        if (!rst_n) begin
            m_reqp = 0; m_fly = 0; m_doom = 0; m_hit = 0;
            m_held = '0; m_ov = 0; m_op = '0; m_ord = '0;
            return;
        end
        if (flush) begin
            m_ov = 0;
        end else if (!stall) begin
            m_ov = valid && rdy;
            m_op = payload;
            if (m_hit) m_ord = m_held;
        end
        if (m_doom) begin
            if (rsp_valid) m_doom = 0;
        end else if (m_fly) begin
            if (rsp_valid) begin
                m_fly = 0;
                if (!flush) begin
                    m_hit  = 1;
                    m_held = rsp_data;
                end
            end else if (flush) begin
                m_fly  = 0;
                m_doom = 1;
            end
        end else if (m_reqp) begin
            if (flush) begin
                m_reqp = 0;
                m_doom = req_ready;
            end else if (req_ready) begin
                m_reqp = 0;
                m_fly  = 1;
            end
        end else if (m_hit) begin
            if (flush || !stall) m_hit = 0;
        end else if (valid && needs_req && !flush) begin
            m_reqp = 1;
        end
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0; valid = 0; needs_req = 0;
        req_ready = 0; rsp_valid = 0; payload = '0; rsp_data = '0;
        model_step();
        @(posedge clk);
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            chk("o_req_valid", 64'(req_valid), 64'(m_reqp));
            chk("o_valid", 64'(out_valid), 64'(m_ov));
            chk("o_payload", out_payload, m_op);
            chk("o_rsp_data", 64'(out_rsp), 64'(m_ord));

            rst_n     = (cyc < 2) ? 1'b0 : ($urandom_range(99) != 0);
            flush     = ($urandom_range(9) == 0);
            stall     = ($urandom_range(3) == 0);
            valid     = ($urandom_range(4) != 0);
            needs_req = ($urandom_range(1) == 0);
            req_ready = ($urandom_range(2) == 0);
            rsp_valid = ($urandom_range(2) == 0);
            payload   = {$urandom, $urandom};
            rsp_data  = $urandom;
            #1;
            chk("o_ready", 64'(ready), 64'(model_ready()));
            model_step();
        end
        @(negedge clk);
        chk("final o_valid", 64'(out_valid), 64'(m_ov));
        chk("final o_rsp_data", 64'(out_rsp), 64'(m_ord));
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
